// File: rtl/db_pkg.sv
// Shared types and constants for the key-value DB request path.
// Holds the default key/flag widths, DB status codes and arbiter states.
package db_pkg;

    localparam int DB_KEY_SIZE  = 96;
    localparam int DB_FLAG_SIZE = 4;

    localparam logic [DB_FLAG_SIZE-1:0] SUSPECTION = DB_FLAG_SIZE'(1);
    localparam logic [DB_FLAG_SIZE-1:0] ARREST     = DB_FLAG_SIZE'(2);
    localparam logic [DB_FLAG_SIZE-1:0] FILTERED   = DB_FLAG_SIZE'(3);
    localparam logic [DB_FLAG_SIZE-1:0] EXPIRED    = DB_FLAG_SIZE'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/db_tag_fifo.sv
// Synchronous tag FIFO remembering which requester issued each DB command.
// Pointers carry an extra wrap bit so count is a plain subtraction.
module db_tag_fifo #(
    parameter int DW    = 1,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/db_req_arb.sv
// Round-robin sharing of the single DB lookup/update port between requesters.
// Commands are single-cycle pulses with a forced idle gap; responses routed by tag.
module db_req_arb
    import db_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int KEY_SIZE  = DB_KEY_SIZE,
    parameter int FLAG_SIZE = DB_FLAG_SIZE,
    parameter int ISSUE_GAP = 2,
    parameter int MAX_OUT   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*KEY_SIZE-1:0]  req_key,
    input  logic [N_REQ*FLAG_SIZE-1:0] req_flag,
    output logic                       db_valid,
    output logic [KEY_SIZE-1:0]        db_key,
    output logic [FLAG_SIZE-1:0]       db_flag,
    input  logic                       db_out_valid,
    input  logic [FLAG_SIZE-1:0]       db_out_flag,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [FLAG_SIZE-1:0]       rsp_flag,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_orphan
);

    localparam int PW = $clog2(N_REQ);
    localparam int OW = $clog2(MAX_OUT);
    localparam int GW = $clog2(ISSUE_GAP + 1);

    arb_state_e     state;
    arb_state_e     state_nx;
    logic [GW-1:0]  gap_cnt;
    logic [GW-1:0]  gap_nx;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  win;
    logic           found;
    logic [PW:0]    sum;
    logic           grant;
    logic           pop;
    logic           can_grant;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PW-1:0]  head;
    logic [OW:0]    count;
    logic [N_REQ-1:0] rsp_q;

    // A response popping this cycle frees a slot for a grant this cycle.
    assign pop       = db_out_valid & ~fifo_empty;
    assign can_grant = ~fifo_full | pop;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
            if (!found && req_valid[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        req_ready = '0;
        db_valid  = 1'b0;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && can_grant) begin
                    req_ready[win] = 1'b1;
                    grant          = 1'b1;
                    state_nx       = ISSUE;
                end
            end
            ISSUE: begin
                db_valid = 1'b1;
                state_nx = GAP;
                gap_nx   = GW'(ISSUE_GAP - 1);
            end
            GAP: begin
                if (gap_cnt == '0) state_nx = IDLE;
                else               gap_nx   = gap_cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Nothing may leave the block while it is being reset.
        if (rst) begin
            req_ready = '0;
            db_valid  = 1'b0;
            grant     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            ptr        <= '0;
            db_key     <= '0;
            db_flag    <= '0;
            rsp_q      <= '0;
            rsp_flag   <= '0;
            err_orphan <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
            if (grant) begin
                db_key  <= req_key[win*KEY_SIZE +: KEY_SIZE];
                db_flag <= req_flag[win*FLAG_SIZE +: FLAG_SIZE];
                ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
            rsp_q <= '0;
            if (pop) begin
                rsp_q[head] <= 1'b1;
                rsp_flag    <= db_out_flag;
            end
            if (db_out_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    db_tag_fifo #(
        .DW    (PW),
        .DEPTH (MAX_OUT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (win),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rsp_valid   = rsp_q & {N_REQ{~rst}};
    assign outstanding = count;

endmodule

// File: tb/tb_db_req_arb.sv
// Bench for db_req_arb: random and directed traffic against a queue-based model.
module tb_db_req_arb;

    localparam int N   = 2;
    localparam int KS  = 96;
    localparam int FS  = 4;
    localparam int GAP = 2;
    localparam int MO  = 8;
    localparam int OW  = $clog2(MO);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*KS-1:0] req_key = '0;
    logic [N*FS-1:0] req_flag = '0;
    logic            db_valid;
    logic [KS-1:0]   db_key;
    logic [FS-1:0]   db_flag;
    logic            db_out_valid = 1'b0;
    logic [FS-1:0]   db_out_flag = '0;
    logic [N-1:0]    rsp_valid;
    logic [FS-1:0]   rsp_flag;
    logic [OW:0]     outstanding;
    logic            err_orphan;

    db_req_arb #(
        .N_REQ(N), .KEY_SIZE(KS), .FLAG_SIZE(FS),
        .ISSUE_GAP(GAP), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_flag(req_flag),
        .db_valid(db_valid), .db_key(db_key), .db_flag(db_flag),
        .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
        .rsp_valid(rsp_valid), .rsp_flag(rsp_flag),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int            tq[$];
    int            m_ptr = 0;
    bit            granted_any = 0;
    int            last_grant = -100;
    logic [N-1:0]  e_rsp = '0;
    logic [FS-1:0] e_rsp_flag = '0;
    bit            e_err = 0;
    logic [KS-1:0] e_key = '0;
    logic [FS-1:0] e_flag = '0;

    bit key_rand = 1;
    int db_lat = 3;
    bit db_stall = 0;
    bit inj_dov = 0;
    int fixed_flag = -1;
    int pend[$];
    int pulses[$];
    int obs_grants[$];
    logic [N-1:0] last_ready;
    logic [N-1:0] last_rsp;
    logic [OW:0]  last_out;

    task automatic model_reset();
        tq.delete();
        pend.delete();
        m_ptr = 0;
        granted_any = 0;
        last_grant = -100;
        e_rsp = '0;
        e_rsp_flag = '0;
        e_err = 0;
        e_key = '0;
        e_flag = '0;
    endtask

    task automatic model_check();
        int npop;
        int win;
        int t;
        bit can;
        logic [N-1:0] e_ready;
        logic e_dbv;
        last_ready = req_ready;
        last_out = outstanding;
        last_rsp = rsp_valid;
        if (rst) begin
            vectors++;
            if (req_ready !== '0 || db_valid !== 1'b0 || rsp_valid !== '0) begin
                miscompares++;
                $display("FAIL reset_gate cyc=%0d: ready=%b dbv=%b rsp=%b, required all 0",
                         cyc, req_ready, db_valid, rsp_valid);
            end
            model_reset();
            return;
        end
        npop = (db_out_valid && tq.size() > 0) ? 1 : 0;
        can = (!granted_any || cyc >= last_grant + GAP + 2)
              && (tq.size() - npop < MO);
        win = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (win < 0 && req_valid[i]) win = i;
        end
        e_ready = '0;
        if (can && win >= 0) e_ready[win] = 1'b1;
        e_dbv = granted_any && (cyc == last_grant + 1);

        vectors++;
        if (req_ready !== e_ready) begin
            miscompares++;
            $display("FAIL req_ready cyc=%0d: got %b, required %b", cyc, req_ready, e_ready);
        end
        vectors++;
        if (db_valid !== e_dbv) begin
            miscompares++;
            $display("FAIL db_valid cyc=%0d: got %b, required %b", cyc, db_valid, e_dbv);
        end
        vectors++;
        if (rsp_valid !== e_rsp) begin
            miscompares++;
            $display("FAIL rsp_valid cyc=%0d: got %b, required %b", cyc, rsp_valid, e_rsp);
        end
        vectors++;
        if (rsp_flag !== e_rsp_flag) begin
            miscompares++;
            $display("FAIL rsp_flag cyc=%0d: got %0h, required %0h", cyc, rsp_flag, e_rsp_flag);
        end
        vectors++;
        if (outstanding !== (OW+1)'(tq.size())) begin
            miscompares++;
            $display("FAIL outstanding cyc=%0d: got %0d, required %0d",
                     cyc, outstanding, tq.size());
        end
        vectors++;
        if (err_orphan !== e_err) begin
            miscompares++;
            $display("FAIL err_orphan cyc=%0d: got %b, required %b", cyc, err_orphan, e_err);
        end
        vectors++;
        if (db_key !== e_key || db_flag !== e_flag) begin
            miscompares++;
            $display("FAIL db_cmd cyc=%0d: got %h/%h, required %h/%h",
                     cyc, db_key, db_flag, e_key, e_flag);
        end

        if (db_valid === 1'b1) begin
            pulses.push_back(cyc);
            pend.push_back(cyc);
        end
        for (int k = 0; k < N; k++)
            if (req_ready[k] === 1'b1 && req_valid[k]) obs_grants.push_back(k);

        e_rsp = '0;
        if (npop != 0) begin
            t = tq.pop_front();
            e_rsp[t] = 1'b1;
            e_rsp_flag = db_out_flag;
        end else if (db_out_valid) begin
            e_err = 1;
        end
        if (e_ready != '0) begin
            tq.push_back(win);
            m_ptr = (win + 1) % N;
            last_grant = cyc;
            granted_any = 1;
            e_key = req_key[win*KS +: KS];
            e_flag = req_flag[win*FS +: FS];
        end
    endtask

    task automatic run_cycle(input logic r);
        rst = r;
        if (key_rand)
            for (int i = 0; i < N; i++) begin
                req_key[i*KS +: KS] = {$urandom(), $urandom(), $urandom()};
                req_flag[i*FS +: FS] = FS'($urandom());
            end
        db_out_valid = 1'b0;
        db_out_flag = (fixed_flag >= 0) ? FS'(fixed_flag) : FS'($urandom());
        if (inj_dov) begin
            db_out_valid = 1'b1;
            inj_dov = 0;
            if (pend.size() > 0) void'(pend.pop_front());
        end else if (!db_stall && pend.size() > 0 && cyc >= pend[0] + db_lat) begin
            db_out_valid = 1'b1;
            void'(pend.pop_front());
        end
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        db_stall = 0;
        n = 0;
        while ((outstanding != 0 || pend.size() > 0 || n < 4) && n < 300) begin
            run_cycle(1'b0);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL drain_timeout: outstanding=%0d, required 0", outstanding);
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        run_cycle(1'b1);
        run_cycle(1'b1);
        req_valid = '0;
        run_cycle(1'b0);
        vectors++;
        if (last_out !== '0 || last_rsp !== '0 || last_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_state: out=%0d rsp=%b ready=%b, required 0",
                     last_out, last_rsp, last_ready);
        end
    endtask

    task automatic test_single();
        logic [KS-1:0] k;
        k = 96'h0A000001_0A000002_1F900000;
        key_rand = 0;
        req_key[0 +: KS] = k;
        req_flag[0 +: FS] = FS'(1);
        db_lat = 5;
        fixed_flag = 3;
        req_valid = 2'b01;
        run_cycle(1'b0);
        req_valid = '0;
        run_cycle(1'b0);
        vectors++;
        if (db_key !== k || db_flag !== FS'(1)) begin
            miscompares++;
            $display("FAIL single_cmd: got %h/%h, required %h/1", db_key, db_flag, k);
        end
        for (int i = 0; i < 8; i++) run_cycle(1'b0);
        vectors++;
        if (rsp_flag !== FS'(3) || outstanding !== '0) begin
            miscompares++;
            $display("FAIL single_rsp: got flag=%0d out=%0d, required 3/0",
                     rsp_flag, outstanding);
        end
        fixed_flag = -1;
        key_rand = 1;
    endtask

    task automatic test_alternate();
        int g0;
        int p0;
        int n;
        g0 = obs_grants.size();
        p0 = pulses.size();
        db_lat = 2;
        req_valid = 2'b11;
        n = 0;
        while (obs_grants.size() < g0 + 12 && n < 100) begin
            run_cycle(1'b0);
            n++;
        end
        req_valid = '0;
        run_cycle(1'b0);
        vectors++;
        if (pulses.size() - p0 != 12) begin
            miscompares++;
            $display("FAIL alt_pulses: got %0d, required 12", pulses.size() - p0);
        end else begin
            for (int i = 1; i < 12; i++) begin
                vectors++;
                if (obs_grants[g0+i] == obs_grants[g0+i-1]
                    || pulses[p0+i] - pulses[p0+i-1] != GAP + 2) begin
                    miscompares++;
                    $display("FAIL alt_seq #%0d: grant %0d after %0d, spacing %0d, required %0d",
                             i, obs_grants[g0+i], obs_grants[g0+i-1],
                             pulses[p0+i] - pulses[p0+i-1], GAP + 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_full();
        int p0;
        p0 = pulses.size();
        db_stall = 1;
        req_valid = 2'b01;
        for (int i = 0; i < 40; i++) run_cycle(1'b0);
        vectors++;
        if (pulses.size() - p0 != MO || outstanding !== (OW+1)'(MO) || last_ready !== '0) begin
            miscompares++;
            $display("FAIL full: pulses=%0d out=%0d ready=%b, required %0d/%0d/0",
                     pulses.size() - p0, outstanding, last_ready, MO, MO);
        end
        db_stall = 0;
        db_lat = 0;
        run_cycle(1'b0);
        vectors++;
        if (last_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL full_pop_grant: ready=%b, required 01", last_ready);
        end
        drain();
    endtask

    task automatic test_orphan();
        inj_dov = 1;
        run_cycle(1'b0);
        run_cycle(1'b0);
        vectors++;
        if (err_orphan !== 1'b1 || last_rsp !== '0) begin
            miscompares++;
            $display("FAIL orphan: err=%b rsp=%b, required 1/00", err_orphan, last_rsp);
        end
        db_lat = 1;
        req_valid = 2'b10;
        run_cycle(1'b0);
        req_valid = '0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0);
        vectors++;
        if (err_orphan !== 1'b1) begin
            miscompares++;
            $display("FAIL orphan_sticky: err=%b, required 1", err_orphan);
        end
        drain();
    endtask

    task automatic test_reset_issue();
        int g0;
        int n;
        g0 = obs_grants.size();
        db_stall = 1;
        req_valid = 2'b01;
        n = 0;
        while (obs_grants.size() < g0 + 3 && n < 50) begin
            run_cycle(1'b0);
            n++;
        end
        vectors++;
        if (outstanding !== (OW+1)'(3)) begin
            miscompares++;
            $display("FAIL rst_issue_pre: out=%0d, required 3", outstanding);
        end
        req_valid = 2'b11;
        run_cycle(1'b1);
        db_stall = 0;
        run_cycle(1'b0);
        vectors++;
        if (last_out !== '0 || err_orphan !== 1'b0 || last_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_issue_post: out=%0d err=%b ready=%b, required 0/0/01",
                     last_out, err_orphan, last_ready);
        end
        drain();
    endtask

    task automatic test_same_cycle();
        int g0;
        int n;
        g0 = obs_grants.size();
        db_stall = 1;
        req_valid = 2'b01;
        n = 0;
        while (obs_grants.size() < g0 + 4 && n < 50) begin
            run_cycle(1'b0);
            n++;
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) run_cycle(1'b0);
        req_valid = 2'b01;
        inj_dov = 1;
        run_cycle(1'b0);
        req_valid = '0;
        run_cycle(1'b0);
        vectors++;
        if (last_out !== (OW+1)'(4) || last_rsp !== 2'b01) begin
            miscompares++;
            $display("FAIL push_pop: out=%0d rsp=%b, required 4/01", last_out, last_rsp);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) db_lat = $urandom_range(4, 0);
            if ($urandom_range(9, 0) == 0) db_stall = ~db_stall;
            req_valid = N'($urandom());
            run_cycle(1'b0);
        end
        drain();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_orphan();
        test_reset_issue();
        test_same_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
